// File: rtl/rot_sincos_scheduler.sv
// Shares one CORDIC sin/cos core across the X, Y and Z rotation axes: issues three
// angles back-to-back, collects the results in issue order and guards with a watchdog.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; results and err held
// S_ISSUE | driving X, Y, Z angles to the CORDIC on three cycles
// S_WAIT  | all angles issued, collecting remaining results
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module rot_sincos_scheduler #(
   parameter int CORDIC_LAT = 20,
   parameter int TIMEOUT    = 64
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] angle_x,
   input  logic [15:0] angle_y,
   input  logic [15:0] angle_z,
   output logic        cordic_valid,
   output logic [15:0] cordic_angle,
   input  logic        cordic_valid_out,
   input  logic [31:0] cordic_sincos,
   output logic [15:0] sin_x,
   output logic [15:0] cos_x,
   output logic [15:0] sin_y,
   output logic [15:0] cos_y,
   output logic [15:0] sin_z,
   output logic [15:0] cos_z,
   output logic        busy,
   output logic        done,
   output logic        err
);

   if (TIMEOUT < 8 || TIMEOUT > 255 || CORDIC_LAT < 1) begin : g_param_chk
      $error("rot_sincos_scheduler: TIMEOUT must be 8..255 and CORDIC_LAT at least 1");
   end

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  issue_cnt, issue_d;
   logic [1:0]  res_cnt, res_d;
   logic [7:0]  wd_cnt, wd_d;
   logic [15:0] ang_y_q, ang_z_q;
   logic [15:0] angle_d;
   logic        valid_d, err_d, cap, accept;

   // X goes out on the same edge that latches the request, so only Y and Z are held.
   always_comb begin
      state_d = state_q;
      issue_d = issue_cnt;
      res_d   = res_cnt;
      wd_d    = wd_cnt;
      err_d   = err;
      valid_d = 1'b0;
      angle_d = cordic_angle;
      accept  = 1'b0;
      cap     = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && cordic_valid_out
                && (res_cnt != 2'd3);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = S_ISSUE;
               issue_d = 2'd0;
               res_d   = 2'd0;
               wd_d    = 8'd0;
               err_d   = 1'b0;
               valid_d = 1'b1;
               angle_d = angle_x;
            end
         end
         S_ISSUE, S_WAIT: begin
            wd_d = wd_cnt + 8'd1;
            if (cap) res_d = res_cnt + 2'd1;
            if (state_q == S_ISSUE) begin
               if (issue_cnt == 2'd2) begin
                  state_d = S_WAIT;
               end else begin
                  issue_d = issue_cnt + 2'd1;
                  valid_d = 1'b1;
                  angle_d = (issue_cnt == 2'd0) ? ang_y_q : ang_z_q;
               end
            end
            // A completing capture wins over the watchdog in the same cycle.
            if (cap && (res_cnt == 2'd2)) begin
               state_d = S_DONE;
               valid_d = 1'b0;
            end else if (wd_cnt == WD_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               valid_d = 1'b0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         issue_cnt    <= 2'd0;
         res_cnt      <= 2'd0;
         wd_cnt       <= 8'd0;
         ang_y_q      <= 16'd0;
         ang_z_q      <= 16'd0;
         cordic_valid <= 1'b0;
         cordic_angle <= 16'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         state_q      <= state_d;
         issue_cnt    <= issue_d;
         res_cnt      <= res_d;
         wd_cnt       <= wd_d;
         cordic_valid <= valid_d;
         cordic_angle <= angle_d;
         busy         <= (state_d == S_ISSUE) || (state_d == S_WAIT);
         done         <= (state_d == S_DONE);
         err          <= err_d;
         if (accept) begin
            ang_y_q <= angle_y;
            ang_z_q <= angle_z;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst) begin
         sin_x <= 16'd0;
         cos_x <= 16'd0;
         sin_y <= 16'd0;
         cos_y <= 16'd0;
         sin_z <= 16'd0;
         cos_z <= 16'd0;
      end else if (cap) begin
         case (res_cnt)
            2'd0:    {sin_x, cos_x} <= cordic_sincos;
            2'd1:    {sin_y, cos_y} <= cordic_sincos;
            default: {sin_z, cos_z} <= cordic_sincos;
         endcase
      end
   end

endmodule

// File: tb/tb_rot_sincos_scheduler.sv
// Bench for rot_sincos_scheduler: behavioural CORDIC with programmable latency and
// result count, trig reference via $sin/$cos, randomized angles and latencies.
module tb_rot_sincos_scheduler;

   localparam int TIMEOUT = 64;

   logic        CLK = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] angle_x = 16'd0, angle_y = 16'd0, angle_z = 16'd0;
   logic        cordic_valid;
   logic [15:0] cordic_angle;
   logic        cordic_valid_out = 1'b0;
   logic [31:0] cordic_sincos = 32'd0;
   logic [15:0] sin_x, cos_x, sin_y, cos_y, sin_z, cos_z;
   logic        busy, done, err;

   int n_cmp = 0;
   int n_err = 0;

   rot_sincos_scheduler #(.CORDIC_LAT(20), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .rst(rst), .start(start),
      .angle_x(angle_x), .angle_y(angle_y), .angle_z(angle_z),
      .cordic_valid(cordic_valid), .cordic_angle(cordic_angle),
      .cordic_valid_out(cordic_valid_out), .cordic_sincos(cordic_sincos),
      .sin_x(sin_x), .cos_x(cos_x), .sin_y(sin_y), .cos_y(cos_y),
      .sin_z(sin_z), .cos_z(cos_z),
      .busy(busy), .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] q14(input real v);
      real s;
      int  i;
      s = v * 16384.0;
      if (s >= 0.0) i = $rtoi(s + 0.5);
      else          i = -$rtoi(-s + 0.5);
      return 16'(i);
   endfunction

   function automatic logic [31:0] ref_sincos(input logic [15:0] a);
      real th;
      th = $itor($signed(a)) / 8192.0;
      return {q14($sin(th)), q14($cos(th))};
   endfunction

   function automatic logic [15:0] rand_angle();
      int v;
      v = int'($urandom_range(51470, 0)) - 25735;
      return 16'(v);
   endfunction

   // CORDIC model: angle seen in the cycle after edge t answers in the cycle after edge t+lat.
   typedef struct {
      int          due;
      logic [31:0] data;
   } res_t;

   res_t pipe[$];
   int   cyc = 0;
   int   lat = 20;
   int   nret = 3;
   int   push_base = 0;
   int   push_total = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (cordic_valid === 1'b1 && (push_total - push_base) < nret) begin
         res_t r;
         r.due  = cyc + lat;
         r.data = ref_sincos(cordic_angle);
         pipe.push_back(r);
         push_total <= push_total + 1;
      end
   end

   always @(posedge CLK) begin
      #1;
      if (pipe.size() > 0 && pipe[0].due == cyc) begin
         cordic_valid_out = 1'b1;
         cordic_sincos    = pipe[0].data;
         void'(pipe.pop_front());
      end else begin
         cordic_valid_out = 1'b0;
         cordic_sincos    = $urandom;
      end
   end

   logic [15:0] exp_sin[3];
   logic [15:0] exp_cos[3];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_sin_x"}, sin_x, exp_sin[0]);
      check({tag, "_cos_x"}, cos_x, exp_cos[0]);
      check({tag, "_sin_y"}, sin_y, exp_sin[1]);
      check({tag, "_cos_y"}, cos_y, exp_cos[1]);
      check({tag, "_sin_z"}, sin_z, exp_sin[2]);
      check({tag, "_cos_z"}, cos_z, exp_cos[2]);
   endtask

   task automatic run_op(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az,
                         input int l, input int nr, input bit poke);
      logic [15:0] ang[3];
      logic [15:0] seen[3];
      int nval, ndone, done_k, last_vk, k;
      bit fin;
      nval = 0; ndone = 0; done_k = -1; last_vk = -1; k = 0; fin = 1'b0;
      ang[0] = ax; ang[1] = ay; ang[2] = az;
      for (int i = 0; i < 3; i++) seen[i] = 16'd0;
      lat = l; nret = nr; push_base = push_total;
      for (int i = 0; i < nr; i++) {exp_sin[i], exp_cos[i]} = ref_sincos(ang[i]);
      angle_x = ax; angle_y = ay; angle_z = az;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_rise", busy, 1);
      check("err_clear_on_start", err, 0);
      while (!fin && k < 100) begin
         if (cordic_valid === 1'b1) begin
            if (nval < 3) seen[nval] = cordic_angle;
            nval++;
            last_vk = k;
         end
         if (done === 1'b1) begin
            ndone++;
            done_k = k;
         end
         if (k > 0 && busy === 1'b0) begin
            fin = 1'b1;
         end else begin
            start = poke && (k == 1 || k == 10);
            if (start) begin
               angle_x = ~ax; angle_y = ~ay; angle_z = ax ^ ay;
            end
            tick();
            k++;
         end
      end
      start = 1'b0;
      check("op_end", fin, 1);
      check("valid_cnt", nval, 3);
      check("valid_last", last_vk, 2);
      for (int i = 0; i < 3; i++) check("issue_angle", seen[i], ang[i]);
      if (nr == 3) begin
         check("done_cnt", ndone, 1);
         check("done_lat", done_k, l + 3);
         check("err_clear", err, 0);
      end else begin
         check("done_cnt_timeout", ndone, 0);
         check("err_set", err, 1);
         check("err_lat", k, TIMEOUT);
      end
      tick();
      check("done_pulse", done, 0);
      check("busy_idle", busy, 0);
      check_outputs("slot");
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         exp_sin[i] = 16'd0;
         exp_cos[i] = 16'd0;
      end

      // reset held with start high
      rst = 1'b0; start = 1'b1;
      angle_x = rand_angle(); angle_y = rand_angle(); angle_z = rand_angle();
      repeat (3) tick();
      check("rst_valid", cordic_valid, 0);
      check("rst_angle", cordic_angle, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check_outputs("rst");
      start = 1'b0; rst = 1'b1;
      tick();
      check("idle_after_rst", busy, 0);

      // nominal
      run_op(16'h0000, 16'h1922, 16'hE6DE, 20, 3, 1'b0);
      check("nom_cos_x", cos_x, 16'h4000);
      check("nom_sin_x", sin_x, 16'h0000);
      check("nom_sin_y", sin_y, 16'h2D41);
      check("nom_sin_z", sin_z, 16'hD2BF);

      // short latency, captures overlap issue
      run_op(rand_angle(), rand_angle(), rand_angle(), 1, 3, 1'b0);

      // start pulses during ISSUE and WAIT are ignored
      run_op(rand_angle(), rand_angle(), rand_angle(), 20, 3, 1'b1);

      // timeout with only two results, then recovery
      run_op(rand_angle(), rand_angle(), rand_angle(), 20, 2, 1'b0);
      run_op(rand_angle(), rand_angle(), rand_angle(), 20, 3, 1'b0);

      // reset mid-operation after one capture
      begin
         logic [15:0] ax;
         ax = rand_angle();
         lat = 20; nret = 3; push_base = push_total;
         angle_x = ax; angle_y = rand_angle(); angle_z = rand_angle();
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (21) tick();
         check("mid_sin_x_captured", {sin_x, cos_x}, ref_sincos(ax));
         check("mid_busy", busy, 1);
         rst = 1'b0;
         tick();
         rst = 1'b1;
         for (int i = 0; i < 3; i++) begin
            exp_sin[i] = 16'd0;
            exp_cos[i] = 16'd0;
         end
         check("mid_rst_busy", busy, 0);
         check("mid_rst_valid", cordic_valid, 0);
         repeat (6) begin
            tick();
            check("stale_done", done, 0);
            check("stale_sin_y", sin_y, 0);
            check("stale_sin_z", sin_z, 0);
         end
         check_outputs("stale");
      end
      run_op(rand_angle(), rand_angle(), rand_angle(), 20, 3, 1'b0);

      // randomized latencies and result counts
      for (int n = 0; n < 8; n++) begin
         int l, nr;
         l  = int'($urandom_range(40, 1));
         nr = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 0)) : 3;
         run_op(rand_angle(), rand_angle(), rand_angle(), l, nr, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rot_sincos_scheduler.md
# rot_sincos_scheduler

Time-multiplexes one shared `cordic_sin_cos` instance across the three rotation axes (X, Y, Z) of the geometry front end. On `start` it latches three angles and issues them back-to-back to the CORDIC. It collects the three sin/cos pairs in issue order and presents them as registered outputs for the rotation-matrix builders. A watchdog flags a CORDIC that fails to return all results.

## Interface
- `CORDIC_LAT`, 20: nominal CORDIC latency in cycles, from `s_axis_phase_tvalid` to `m_axis_dout_tvalid`; documentation and bench use only.
- `TIMEOUT`, 64: cycles allowed from first issue to third result capture; range 8..255.
- `CLK`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `angle_x`, `angle_y`, `angle_z`  in  16 each  signed Q1.2.13 radians.
- `cordic_valid`  out  1  drives `s_axis_phase_tvalid`.
- `cordic_angle`  out  16  drives `s_axis_phase_tdata`.
- `cordic_valid_out`  in  1  from `m_axis_dout_tvalid`.
- `cordic_sincos`  in  32  from `m_axis_dout_tdata`; [31:16] = sin, [15:0] = cos, both Q1.1.14.
- `sin_x`, `cos_x`, `sin_y`, `cos_y`, `sin_z`, `cos_z`  out  16 each  captured results.
- `busy`  out  1  high in ISSUE and WAIT.
- `done`  out  1  one-cycle pulse when all six results are valid.
- `err`  out  1  sticky timeout flag; cleared by the next accepted `start`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On `start`=1: latch the three angles, clear `err`, `issue_cnt`, `res_cnt` and `wd_cnt`; go to ISSUE.
  - `start` in any other state is ignored; no queuing.
- **ISSUE** (exactly 3 cycles)
  - `cordic_valid`=1 each cycle; `cordic_angle` = X, Y, Z for `issue_cnt` = 0, 1, 2.
  - After `issue_cnt`=2, go to WAIT. The CORDIC has no backpressure.
- **Result capture** (ISSUE and WAIT)
  - Each cycle with `cordic_valid_out`=1 and `res_cnt`<3: write `cordic_sincos` to the axis slot selected by `res_cnt` (0=X, 1=Y, 2=Z), then increment `res_cnt`.
  - The third capture moves the FSM to DONE, even if it occurs in ISSUE.
  - `cordic_valid_out` in IDLE or DONE, or with `res_cnt`=3, is ignored.
  - Result outputs are held between operations and are not cleared by `start`.
- **Watchdog**
  - `wd_cnt` increments every cycle in ISSUE and WAIT.
  - When `wd_cnt`=TIMEOUT−1 and no capture completes that cycle: set `err`=1 and go to IDLE with no `done`.
  - Partially captured slots keep their new values.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **Reset**
  - While `rst`=0 at an edge: FSM to IDLE; all counters, latched angles, `cordic_valid`, `cordic_angle`, all result outputs, `busy`, `done` and `err` go to 0.
  - Reset mid-operation abandons the operation. CORDIC results still in flight arrive while in IDLE and are ignored.
- No arithmetic is performed; values are passed through bit-exact.

## Timing
- Take `start` sampled high at edge t.
- `cordic_valid` is high in the cycles after edges t, t+1 and t+2; `busy` goes high from edge t.
- With CORDIC latency L, results appear in the cycles after edges t+L, t+L+1 and t+L+2, and are captured at edges t+L+1, t+L+2 and t+L+3.
- `done` is high for the one cycle after edge t+L+3. `busy` is low in that same cycle.
- Minimum start-to-done is L+4 cycles; with the default CORDIC_LAT this is 24.
- A new `start` is accepted in the first IDLE cycle after DONE, giving a throughput of one request per L+5 cycles.
- All outputs are registered.

## Test plan
- **Reset**
  - Stimulus: hold `rst`=0 for 3 cycles with `start`=1.
  - Required: all outputs 0, `busy`=0, no `cordic_valid`.
- **Nominal operation**
  - Stimulus: CORDIC model with L=20; angles X=0x0000, Y=0x1922 (π/4), Z=0xE6DE (−π/4).
  - Required: `cordic_angle` sequence 0x0000, 0x1922, 0xE6DE.
  - Required: `done` 24 cycles after `start`; `cos_x`=0x4000, `sin_x`=0x0000, `sin_y`=0x2D41, `sin_z`=0xD2BF.
- **Short latency**
  - Stimulus: L=1.
  - Required: captures overlap ISSUE; `done` at t+5; slots still X, Y, Z in order.
- **Ignored start**
  - Stimulus: pulse `start` again in ISSUE and in WAIT, with different angles.
  - Required: exactly three `cordic_valid` cycles, the original angles, and one `done`.
- **Timeout**
  - Stimulus: model returns only 2 results; TIMEOUT=64.
  - Required: `err`=1 at edge t+64, FSM in IDLE, no `done`.
  - Required: a following `start` clears `err` and completes normally.
- **Reset mid-operation**
  - Stimulus: assert `rst` in WAIT with 1 result captured; release; let stale results arrive.
  - Required: outputs stay 0, no `done`; the next `start` completes with correct values.
